// File: rtl/dcache_controller_if.sv
// dcache_controller_if: CPU data port and memory block port of the data cache
//   CPU side : read, write, address, writedata -> cache; readdata, busywait <- cache
//   mem side : mem_read, mem_write, mem_address, mem_writedata <- cache; mem_readdata, mem_busywait -> cache
//   modport slave is the cache view, modport master the CPU/memory environment view
interface dcache_controller_if #(parameter int TAG_W = 3, parameter int IDX_W = 3);
  logic                   read;
  logic                   write;
  logic [TAG_W+IDX_W+1:0] address;
  logic [7:0]             writedata;
  logic [7:0]             readdata;
  logic                   busywait;
  logic                   mem_read;
  logic                   mem_write;
  logic [TAG_W+IDX_W-1:0] mem_address;
  logic [31:0]            mem_writedata;
  logic [31:0]            mem_readdata;
  logic                   mem_busywait;
  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate data cache with miss FSM
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : CPU request/response and memory block port (slave view)
module dcache_controller #(
  parameter int TAG_W = 3,
  parameter int IDX_W = 3
) (
  input logic                 clk,
  input logic                 reset,
  dcache_controller_if.slave  bus
);
  localparam int NB = 2 ** IDX_W;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;
  state_t           r_state, w_next;
  logic             r_first;
  logic [31:0]      r_data [NB];
  logic [TAG_W-1:0] r_tag [NB];
  logic [NB-1:0]    r_valid, r_dirty;
  logic [31:0]      r_fetched;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_off;
  logic             w_hit, w_req, w_wr_hit;
  assign w_tag    = bus.address[TAG_W+IDX_W+1 -: TAG_W];
  assign w_idx    = bus.address[IDX_W+1:2];
  assign w_off    = bus.address[1:0];
  assign w_hit    = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_req    = bus.read | bus.write;
  assign w_wr_hit = reset & (r_state == IDLE) & bus.write & w_hit;
  assign bus.readdata = w_hit ? r_data[w_idx][{w_off, 3'b000} +: 8] : 8'h00;
  // Outputs are gated by reset so an aborted miss drops its strobes at once.
  // The memory busy flag is ignored in the first cycle of WRITEBACK/FETCH,
  // since memory has not yet seen the new strobe.
  always_comb begin
    w_next            = r_state;
    bus.busywait      = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writedata = '0;
    if (reset)
      case (r_state)
        IDLE: begin
          bus.busywait = w_req & ~w_hit;
          if (w_req & ~w_hit) w_next = r_dirty[w_idx] ? WRITEBACK : FETCH;
        end
        WRITEBACK: begin
          bus.busywait      = 1'b1;
          bus.mem_write     = 1'b1;
          bus.mem_address   = {r_tag[w_idx], w_idx};
          bus.mem_writedata = r_data[w_idx];
          if (!r_first && !bus.mem_busywait) w_next = FETCH;
        end
        FETCH: begin
          bus.busywait    = 1'b1;
          bus.mem_read    = 1'b1;
          bus.mem_address = {w_tag, w_idx};
          if (!r_first && !bus.mem_busywait) w_next = UPDATE;
        end
        default: begin
          bus.busywait = 1'b1;
          w_next       = IDLE;
        end
      endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_first <= 1'b0;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_next;
      r_first <= w_next != r_state;
      if (r_state == UPDATE) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end else if (w_wr_hit) r_dirty[w_idx] <= 1'b1;
    end
  end
  // Data and tag arrays are not cleared by reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (r_state == FETCH) r_fetched <= bus.mem_readdata;
    if (r_state == UPDATE) begin
      r_data[w_idx] <= r_fetched;
      r_tag[w_idx]  <= w_tag;
    end else if (w_wr_hit) r_data[w_idx][{w_off, 3'b000} +: 8] <= bus.writedata;
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: randomized scoreboard bench for dcache_controller against a flat-memory reference
module tb_dcache_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  dcache_controller_if #(.TAG_W(3), .IDX_W(3)) bus();
  dcache_controller #(.TAG_W(3), .IDX_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {bit rd; logic [7:0] a; logic [7:0] d; bit hit;} exp_t;
  typedef struct {logic [5:0] a; logic [31:0] d;} wb_t;
  exp_t        scq[$];
  wb_t         wbq[$];
  logic [5:0]  fq[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          lat = 1;
  logic [31:0] mem [64];
  logic [7:0]  ref_b [256];
  bit   [7:0]  rv, rdirty;
  logic [2:0]  rt [8];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask
  // memory device: busy for lat cycles after it sees a strobe, then completes
  initial begin
    int cnt;
    bit op;
    logic [5:0] ma;
    logic [31:0] md;
    wb_t w;
    cnt = 0;
    bus.mem_busywait = 1'b0;
    bus.mem_readdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        cnt = 0;
        bus.mem_busywait = 1'b0;
      end else if (cnt > 0) begin
        chk("strobe_held", {31'b0, op ? bus.mem_write : bus.mem_read}, 32'd1);
        cnt--;
        if (cnt == 0) begin
          bus.mem_busywait = 1'b0;
          if (op) mem[ma] = md;
          else bus.mem_readdata = mem[ma];
        end
      end else if (bus.mem_read | bus.mem_write) begin
        op = bus.mem_write;
        ma = bus.mem_address;
        md = bus.mem_writedata;
        cnt = lat;
        bus.mem_busywait = 1'b1;
        if (op) begin
          if (wbq.size() == 0) chk("unexpected_wb", {26'b0, ma}, 32'hffffffff);
          else begin
            w = wbq.pop_front();
            chk("wb_addr", {26'b0, ma}, {26'b0, w.a});
            chk("wb_data", md, w.d);
          end
        end else begin
          if (fq.size() == 0) chk("unexpected_fetch", {26'b0, ma}, 32'hffffffff);
          else chk("fetch_addr", {26'b0, ma}, {26'b0, fq.pop_front()});
        end
      end
    end
  end
  // response monitor: one completion per access, when a request sees busywait low
  initial begin
    bit stalled;
    exp_t e;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) stalled = 1'b0;
      else begin
        chk("strobe_excl", {31'b0, bus.mem_read & bus.mem_write}, 32'd0);
        if (bus.read | bus.write) begin
          if (bus.busywait) stalled = 1'b1;
          else begin
            if (scq.size() == 0) chk("unexpected_done", {24'b0, bus.address}, 32'hffffffff);
            else begin
              e = scq.pop_front();
              chk("hit", {31'b0, !stalled}, {31'b0, e.hit});
              if (e.rd) chk("readdata", {24'b0, bus.readdata}, {24'b0, e.d});
            end
            stalled = 1'b0;
          end
        end
      end
    end
  end
  task automatic access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    logic [2:0] tg, ix;
    bit h;
    int b, n;
    tg = a[7:5];
    ix = a[4:2];
    h = rv[ix] && rt[ix] == tg;
    if (!h) begin
      if (rdirty[ix]) begin
        b = {rt[ix], ix, 2'b00};
        wbq.push_back('{{rt[ix], ix}, {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]}});
      end
      fq.push_back({tg, ix});
      rv[ix] = 1'b1;
      rt[ix] = tg;
      rdirty[ix] = 1'b0;
    end
    if (wr) begin
      ref_b[a] = d;
      rdirty[ix] = 1'b1;
    end
    scq.push_back('{rd & !wr, a, ref_b[a], h});
    bus.read = rd;
    bus.write = wr;
    bus.address = a;
    bus.writedata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busywait && n < 200);
    if (n >= 200) chk("timeout", {24'b0, a}, 32'hffffffff);
    @(posedge clk); #1;
    bus.read = 1'b0;
    bus.write = 1'b0;
  endtask
  initial begin
    int n;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.address = '0;
    bus.writedata = '0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[9] = 32'hDDCCBBAA;
    for (int i = 0; i < 256; i++) ref_b[i] = mem[i/4][(i%4)*8 +: 8];
    rv = '0;
    rdirty = '0;
    #1;
    chk("rst_busywait", {31'b0, bus.busywait}, 32'd0);
    chk("rst_mem_read", {31'b0, bus.mem_read}, 32'd0);
    chk("rst_mem_write", {31'b0, bus.mem_write}, 32'd0);
    chk("rst_readdata", {24'b0, bus.readdata}, 32'd0);
    chk("rst_mem_addr", {26'b0, bus.mem_address}, 32'd0);
    chk("rst_mem_wdata", bus.mem_writedata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    lat = 10;
    fq.push_back(6'h09);
    bus.read = 1'b1;
    bus.address = 8'h25;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_read && n < 20);
    chk("abort_fetch_seen", {31'b0, bus.mem_read}, 32'd1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_mem_read", {31'b0, bus.mem_read}, 32'd0);
    chk("abort_busywait", {31'b0, bus.busywait}, 32'd0);
    bus.read = 1'b0;
    rv = '0;
    rdirty = '0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    lat = 5;
    access(1, 0, 8'h25, 8'h00);
    access(1, 0, 8'h25, 8'h00);
    access(0, 1, 8'h26, 8'h5A);
    access(1, 0, 8'h26, 8'h00);
    lat = 3;
    access(1, 0, 8'hA4, 8'h00);
    access(1, 0, 8'h25, 8'h00);
    access(0, 1, 8'h10, 8'h77);
    access(1, 0, 8'h10, 8'h00);
    access(1, 1, 8'h11, 8'h3C);
    lat = 20;
    access(1, 0, 8'h30, 8'h00);
    access(1, 0, 8'h11, 8'h00);
    for (int k = 0; k < 300; k++) begin
      int m;
      lat = $urandom_range(1, 4);
      m = $urandom_range(0, 2);
      access(m != 1, m != 0, 8'($urandom), 8'($urandom));
    end
    repeat (3) @(negedge clk);
    chk("scq_empty", scq.size(), 32'd0);
    chk("fq_empty", fq.size(), 32'd0);
    chk("wbq_empty", wbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
